exu_div: RTL and testbench
==========================

# exu_div

Iterative 32-bit integer divider executing RV32M DIV/DIVU/REM/REMU. It is the responder on the execute-stage divider interface: the mul/div control unit issues a start pulse with operands and a one-hot op, and this block returns `busy` and a one-cycle `valid` with the result. It produces one quotient bit per cycle through restoring division on operand magnitudes, then applies a sign fixup.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `REG_DATA_WIDTH `` (32): operand and result width.

Ports:
- Reset is asynchronous and active-low. The block has one clock.
- `clk`  in  1  clock.
- `rst_n`  in  1  async active-low reset.
- `start_i`  in  1  request to begin a divide. Sampled only when `busy_o` is 0.
- `dividend_i`  in  DATA_WIDTH  rs1 value.
- `divisor_i`  in  DATA_WIDTH  rs2 value.
- `op_i`  in  4  one-hot op, {remu, rem, divu, div}.
- `result_o`  out  DATA_WIDTH  quotient or remainder. Meaningful when `valid_o`=1.
- `busy_o`  out  1  operation in progress, including the result cycle.
- `valid_o`  out  1  one-cycle result pulse.

## Operation
- States are IDLE, CALC, DONE.
- IDLE:
  - Acceptance: `start_i`=1 with `op_i`≠0.
  - On acceptance, latch the op. If `op_i` is multi-hot, the lowest set bit wins.
  - Signed ops (div, rem) use two's-complement magnitudes. Record `neg_q` = sign(dividend) XOR sign(divisor) AND divisor≠0. Record `neg_r` = sign(dividend).
  - Unsigned ops use the raw operands, with `neg_q` = `neg_r` = 0.
  - Load remainder=0, quotient=|dividend|, count=0, then go to CALC.
  - `start_i` with `op_i`=0 is ignored.
- CALC, one step per cycle:
  - Shift {rem,quot} left by 1.
  - Trial = rem − |divisor| (DATA_WIDTH+1 bits).
  - If trial is non-negative: rem=trial and quotient LSB=1. Otherwise quotient LSB=0.
  - After step 31 (count wraps to 0), go to DONE.
- DONE: drive `result_o` and `valid_o`=1 for one cycle, then return to IDLE.
  - div/divu: `result_o` = `neg_q` ? −quot : quot.
  - rem/remu: `result_o` = `neg_r` ? −rem : rem.
- Required special results. These arise naturally from the rules above and must hold in both configurations:
  - Divisor 0: quotient = all-ones; remainder = dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- `start_i` while `busy_o`=1 is ignored. The in-flight operation is unaffected.
- Reset mid-operation aborts immediately to IDLE. No `valid_o` is produced for the aborted op.

## Timing
- Reset values: `result_o`=0, `busy_o`=0, `valid_o`=0. State is IDLE and all internal registers are 0.
- Acceptance edge is the end of cycle T.
- `busy_o` is high during cycles T+1 … T+33. It is low at T+34.
- `valid_o` is high only at T+33, with `busy_o` still high.
- `busy_o` stays high through DONE. The controller must not see a free divider in the cycle it captures the result, so that capture has priority over a new start.
- `result_o` holds its last value after DONE until the next DONE or reset.
- Back-to-back: the earliest next acceptance is cycle T+34.
- Early-out ops (see Configuration) go IDLE→DONE. They give `busy_o` and `valid_o` at T+1 only.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - At acceptance, detect divisor==0, or |dividend| < |divisor| (unsigned magnitude compare).
  - In that case, skip CALC and go directly to DONE with quot and rem preset:
    - divisor 0: quot = all-ones, rem = |dividend|.
    - small dividend: quot = 0, rem = |dividend|.
  - Sign fixup is unchanged. Latency is 1 cycle.
- Undefined: every op takes the full 33-cycle latency.
- Results are bit-identical in both configurations.

## Structure
- Shared package `exu_div_pkg` holds:
  - `div_state_e` {IDLE, CALC, DONE};
  - op bit indices `DIV_OP_DIV`=0, `DIV_OP_DIVU`=1, `DIV_OP_REM`=2, `DIV_OP_REMU`=3;
  - `DIV_ITER` = DATA_WIDTH.
- Single module, no sub-module. The iteration step and the sign fixup are inline.

## Test plan
- divu, 100 / 7, start at T → `valid_o` at T+33 with `result_o`=14. `busy_o` is high T+1..T+33. remu with the same operands → 2.
- div, 0xFFFFFFF9 / 2 → 0xFFFFFFFD. rem with the same operands → 0xFFFFFFFF.
- div, 5 / 0 → 0xFFFFFFFF; rem → 5. rem 0xFFFFFFF9 / 0 → 0xFFFFFFF9. With `DIV_EARLY_OUT_EN`, valid at T+1.
- div, 0x80000000 / 0xFFFFFFFF → 0x80000000. rem with the same operands → 0.
- Timing and collision checks:
  - Assert start (divu 9/3) at T+10 during a busy op → ignored; the original result arrives at T+33.
  - New start at T+34 is accepted.
  - `valid_o` never pulses twice.
- Reset mid-op: deassert `rst_n` at T+15 → `busy_o`, `valid_o` and `result_o` go to 0 immediately. No valid pulse follows. The next op completes correctly.

Source files
------------

// File: rtl/exu_div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Provides the default operand width when REG_DATA_WIDTH is not set by the build.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

package exu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_OP_DIV  = 0;
  localparam int DIV_OP_DIVU = 1;
  localparam int DIV_OP_REM  = 2;
  localparam int DIV_OP_REMU = 3;

  localparam int DIV_ITER = `REG_DATA_WIDTH;

endpackage

// File: rtl/exu_div.sv
// Restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle on magnitudes, then sign fixup.
// Optional DIV_EARLY_OUT_EN skips iteration for a zero divisor or a dividend smaller than the divisor.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module exu_div
  import exu_div_pkg::*;
#(
  parameter int DATA_WIDTH = `REG_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [3:0]            op_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o,
  output logic                  valid_o
);

  //  state | meaning
  //  IDLE  | waiting for a start with a non-zero op
  //  CALC  | one restoring step per cycle
  //  DONE  | result presented with valid, still busy

  localparam int CW = $clog2(DATA_WIDTH);

  div_state_e            r_state;
  div_state_e            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quot;
  logic [DATA_WIDTH-1:0] r_dvsr;
  logic [DATA_WIDTH-1:0] r_result;
  logic [CW-1:0]         r_cnt;
  logic                  r_is_rem;
  logic                  r_neg_q;
  logic                  r_neg_r;

  logic                  w_sel_div;
  logic                  w_sel_divu;
  logic                  w_sel_rem;
  logic                  w_sel_remu;
  logic                  w_signed;
  logic                  w_is_rem;
  logic                  w_accept;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic                  w_b_zero;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic                  w_early;
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH-1:0] w_trial;
  logic                  w_ge;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_fix;

  // Multi-hot ops resolve to the lowest set bit.
  assign w_sel_div  = op_i[DIV_OP_DIV];
  assign w_sel_divu = ~op_i[DIV_OP_DIV] & op_i[DIV_OP_DIVU];
  assign w_sel_rem  = ~op_i[DIV_OP_DIV] & ~op_i[DIV_OP_DIVU] & op_i[DIV_OP_REM];
  assign w_sel_remu = ~op_i[DIV_OP_DIV] & ~op_i[DIV_OP_DIVU] & ~op_i[DIV_OP_REM] & op_i[DIV_OP_REMU];
  assign w_signed   = w_sel_div | w_sel_rem;
  assign w_is_rem   = w_sel_rem | w_sel_remu;
  assign w_accept   = (r_state == IDLE) & start_i & (|op_i);

  assign w_a_neg  = w_signed & dividend_i[DATA_WIDTH-1];
  assign w_b_neg  = w_signed & divisor_i[DATA_WIDTH-1];
  assign w_b_zero = (divisor_i == '0);
  assign w_a_mag  = w_a_neg ? -dividend_i : dividend_i;
  assign w_b_mag  = w_b_neg ? -divisor_i : divisor_i;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = w_b_zero | (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  // Partial remainder stays below the divisor, so the W-bit difference is exact when taken.
  assign w_shift = {r_rem, r_quot[DATA_WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});
  assign w_trial = w_shift[DATA_WIDTH-1:0] - r_dvsr;
  assign w_last  = (r_cnt == CW'(DATA_WIDTH - 1));

  assign w_fix = r_is_rem ? (r_neg_r ? -r_rem : r_rem)
                          : (r_neg_q ? -r_quot : r_quot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_early ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quot   <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_accept) begin
      r_is_rem <= w_is_rem;
      r_neg_q  <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
      r_neg_r  <= w_a_neg;
      r_dvsr   <= w_b_mag;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quot   <= w_a_mag;
`ifdef DIV_EARLY_OUT_EN
      if (w_early) begin
        r_rem  <= w_a_mag;
        r_quot <= w_b_zero ? '1 : '0;
      end
`endif
    end else if (r_state == CALC) begin
      r_rem  <= w_ge ? w_trial : w_shift[DATA_WIDTH-1:0];
      r_quot <= {r_quot[DATA_WIDTH-2:0], w_ge};
      r_cnt  <= r_cnt + 1'b1;
    end else if (r_state == DONE) begin
      r_result <= w_fix;
    end
  end

  // Result is live during DONE and held afterwards.
  assign result_o = (r_state == DONE) ? w_fix : r_result;
  assign busy_o   = (r_state != IDLE);
  assign valid_o  = (r_state == DONE);

endmodule

// File: tb/tb_exu_div.sv
// Self-checking bench for exu_div: directed corner cases, collisions, reset abort and random ops.
// Expected latency follows DIV_EARLY_OUT_EN when the bench is built with it.
module tb_exu_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [3:0]  op_i = '0;
  logic [31:0] result_o;
  logic        busy_o;
  logic        valid_o;

  int total = 0;
  int bad = 0;

  exu_div #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .op_i       (op_i),
    .result_o   (result_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] op);
    int sel = -1;
    for (int i = 0; i < 4; i++)
      if (op[i] && sel < 0) sel = i;
    return sel;
  endfunction

  // RISC-V semantics with plain 64-bit arithmetic; SV division truncates toward zero.
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    case (lowest(op))
      0: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      1: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      2: return (b == 0) ? a : 32'(sa % sb);
      3: return (b == 0) ? a : 32'(ua % ub);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
`ifdef DIV_EARLY_OUT_EN
    int sel = lowest(op);
    bit sgn = (sel == 0) || (sel == 2);
    longint ma = (sgn && a[31]) ? -longint'($signed(a)) : longint'({32'h0, a});
    longint mb = (sgn && b[31]) ? -longint'($signed(b)) : longint'({32'h0, b});
    return (b == 0 || ma < mb) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after busy drops.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input string tag, input int inj);
    logic [31:0] exp = ref_res(a, b, op);
    int lat = ref_lat(a, b, op);
    start_i = 1'b1;
    dividend_i = a;
    divisor_i = b;
    op_i = op;
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk($sformatf("%s busy@T+%0d", tag, k), {31'b0, busy_o}, {31'b0, (k <= lat)});
      chk($sformatf("%s valid@T+%0d", tag, k), {31'b0, valid_o}, {31'b0, (k == lat)});
      if (k == lat) chk($sformatf("%s result", tag), result_o, exp);
      if (k == lat + 1) chk($sformatf("%s held", tag), result_o, exp);
      if (k == 1) start_i = 1'b0;
      if (inj > 0 && k == inj) begin
        start_i = 1'b1;
        dividend_i = 32'd9;
        divisor_i = 32'd3;
        op_i = 4'b0010;
      end
      if (inj > 0 && k == inj + 1) start_i = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    bit          seen;

    #2;
    chk("reset busy", {31'b0, busy_o}, 32'd0);
    chk("reset valid", {31'b0, valid_o}, 32'd0);
    chk("reset result", result_o, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'd100, 32'd7, 4'b0010, "divu 100/7", 0);
    run_op(32'd100, 32'd7, 4'b1000, "remu 100/7", 0);
    run_op(32'hFFFF_FFF9, 32'd2, 4'b0001, "div -7/2", 0);
    run_op(32'hFFFF_FFF9, 32'd2, 4'b0100, "rem -7/2", 0);
    run_op(32'd5, 32'd0, 4'b0001, "div 5/0", 0);
    run_op(32'd5, 32'd0, 4'b0100, "rem 5/0", 0);
    run_op(32'hFFFF_FFF9, 32'd0, 4'b0100, "rem -7/0", 0);
    run_op(32'hFFFF_FFF9, 32'd0, 4'b0010, "divu -7/0", 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 4'b0001, "div ovf", 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 4'b0100, "rem ovf", 0);
    run_op(32'd3, 32'hFFFF_FFFE, 4'b0001, "div 3/-2", 0);
    run_op(32'd100, 32'd7, 4'b1110, "multihot divu", 0);

    // Start during busy is ignored; the next op goes in back-to-back at T+34.
    run_op(32'd100, 32'd7, 4'b0010, "collide", 10);
    run_op(32'd1000, 32'd33, 4'b1000, "back2back", 0);

    start_i = 1'b1;
    op_i = 4'b0000;
    dividend_i = 32'd50;
    divisor_i = 32'd5;
    @(negedge clk);
    chk("op0 ignored busy", {31'b0, busy_o}, 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    chk("op0 ignored busy2", {31'b0, busy_o}, 32'd0);
    chk("op0 ignored valid", {31'b0, valid_o}, 32'd0);

    // Reset mid-operation.
    start_i = 1'b1;
    dividend_i = 32'd100;
    divisor_i = 32'd7;
    op_i = 4'b0010;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy_o}, 32'd0);
    chk("abort valid", {31'b0, valid_o}, 32'd0);
    chk("abort result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
    end
    chk("no valid after abort", {31'b0, seen}, 32'd0);
    run_op(32'd77, 32'd8, 4'b1000, "after abort", 0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      op = 4'($urandom_range(1, 15));
      run_op(a, b, op, $sformatf("rnd%0d op%b %h/%h", n, op, a, b), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
